mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage for the five-stage integer pipeline, directly downstream of the execute stage (via the EX/MEM register). It passes ALU results through to write-back and executes load and store operations on a single-master request/acknowledge data bus. It handles byte-lane steering, load sign or zero extension, alignment checking and a bus timeout. While a bus access is outstanding it asserts a stall request to the pipeline controller.

## Interface
- BUS_TIMEOUT, 255: number of cycles spent waiting for `bus_ack_i` before the access is abandoned; valid range 1..1023.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- aluop_i  in  8  operation code from `defs.v`. Memory ops are `EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP` and `EXE_SW_OP`; any other code is a pass-through op.
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- wdata_i  in  32  ALU result, used for pass-through ops.
- mem_addr_i  in  32  effective byte address.
- mem_data_i  in  32  store data (rt).
- wd_o  out  5  registered destination address to write-back.
- wreg_o  out  1  registered write enable to write-back.
- wdata_o  out  32  registered write-back data.
- stallreq_o  out  1  combinational stall request to the pipeline controller.
- bus_req_o  out  1  bus request, registered.
- bus_we_o  out  1  1 = write, registered.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- bus_sel_o  out  4  byte-lane enables; bit 3 selects data[31:24]; registered.
- bus_wdata_o  out  32  write data, registered.
- bus_rdata_i  in  32  read data; valid in the cycle `bus_ack_i` is high.
- bus_ack_i  in  1  access complete.
- bus_err_o  out  1  one-cycle error pulse (misaligned access or timeout), registered.

## Operation
- FSM states are IDLE and WAIT. A timeout counter of clog2(BUS_TIMEOUT+1) bits runs only in WAIT.
- IDLE with a pass-through op:
  - Next edge: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i.
  - stallreq_o=0.
- IDLE with a misaligned memory op (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0):
  - No bus access.
  - Next edge: wreg_o=0, wdata_o=0, wd_o=wd_i, bus_err_o=1.
  - stallreq_o=0.
- IDLE with an aligned memory op:
  - stallreq_o=1.
  - Next edge: bus_req_o=1, bus_we_o=(store), address/sel/wdata loaded; go to WAIT, counter cleared; wreg_o=0 (bubble).
- Byte lanes are big-endian:
  - Byte op: sel=4'b1000 >> addr[1:0]; store data={4{rt[7:0]}}.
  - Halfword op: sel=addr[1] ? 4'b0011 : 4'b1100; store data={2{rt[15:0]}}.
  - Word op: sel=4'b1111; store data=rt.
- Load extraction:
  - The lane selected by addr[1:0] is taken from `bus_rdata_i`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- WAIT with `bus_ack_i`=1:
  - stallreq_o=0 in that cycle.
  - Next edge: bus_req_o=0; go to IDLE.
  - Loads: wdata_o=extended data, wreg_o=wreg_i, wd_o=wd_i.
  - Stores: wreg_o=0.
- WAIT without ack:
  - stallreq_o=1; counter increments; wreg_o stays 0.
  - When the counter equals BUS_TIMEOUT-1 and there is still no ack: stallreq_o=0 in that cycle. Next edge: bus_req_o=0, bus_err_o=1, wreg_o=0, wdata_o=0; go to IDLE.
- Inputs are held stable by upstream whenever stallreq_o=1.
- `bus_ack_i` is ignored in IDLE.
- Arithmetic: the counter saturates and never wraps.

## Timing
- Reset, synchronous: all outputs except stallreq_o go to 0, state goes to IDLE, counter goes to 0. stallreq_o is combinational and equals 0 while rst is high.
- Reset during WAIT: bus_req_o drops at that edge and any late ack is ignored.
- Pass-through op latency: 1 cycle, no stall.
- Memory op with ack in the first WAIT cycle:
  - 2 cycles to result.
  - stallreq_o high for exactly 1 cycle (the IDLE issue cycle).
- Memory op with ack after k additional wait cycles: result after 2+k cycles; stall lasts 1+k cycles.
- Ack arriving in the same cycle the counter reaches its limit: ack wins, access completes normally, no error.
- bus_req_o, bus_addr_o, bus_sel_o, bus_we_o and bus_wdata_o are stable from request assertion until the edge after ack.
- bus_err_o is high for exactly one cycle per error.

## Test plan
- Reset: assert rst for 2 cycles during an open WAIT → bus_req_o=0, wreg_o=0 and stallreq_o=0 after the edge; an ack the cycle after is ignored.
- Pass-through: aluop=`EXE_OR_OP`, wd=5, wreg=1, wdata=0x1234_5678 → next cycle wd_o=5, wreg_o=1, wdata_o=0x12345678, stallreq_o never 1.
- LB: addr 0x1003, rdata 0xAABBCC80, ack in the first WAIT cycle → bus_sel_o=4'b0001, wdata_o=0xFFFFFF80 after 2 cycles. Repeat with LBU → wdata_o=0x00000080.
- SH: addr 0x2002, rt 0x0000BEEF, ack after 3 wait cycles → bus_we_o=1, sel=4'b0011, bus_wdata_o=0xBEEFBEEF held 4 cycles, stallreq_o high 4 cycles, wreg_o=0 throughout.
- Misaligned LW at 0x1001 → no bus_req_o, bus_err_o pulse 1 cycle, wreg_o=0, no stall.
- Timeout: BUS_TIMEOUT=4, LW with ack never asserted → req high 4 cycles, then bus_err_o=1 and req=0; a second run with ack in the 4th WAIT cycle → normal completion, no error.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU pass-through, load/store on a req/ack bus
// with big-endian lane steering, alignment checking and a bus timeout.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam int CW = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [7:0]  r_op;
    logic [1:0]  r_off;
    logic [4:0]  r_wd;
    logic        r_wreg;

    logic [4:0]  w_wd_nx;
    logic        w_wreg_nx, w_req_nx, w_we_nx, w_err_nx;
    logic [31:0] w_wdata_nx, w_baddr_nx, w_bwdata_nx;
    logic [3:0]  w_sel_nx;

    logic w_byte, w_half, w_word, w_load, w_store, w_mem, w_misalign, w_lim;
    logic [3:0]  w_sel;
    logic [31:0] w_stdata, w_ldata;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    assign w_byte  = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) || (aluop_i == EXE_SB_OP);
    assign w_half  = (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) || (aluop_i == EXE_SH_OP);
    assign w_word  = (aluop_i == EXE_LW_OP) || (aluop_i == EXE_SW_OP);
    assign w_store = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SH_OP) || (aluop_i == EXE_SW_OP);
    assign w_load  = (w_byte || w_half || w_word) && !w_store;
    assign w_mem   = w_byte || w_half || w_word;
    assign w_misalign = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));

    assign w_sel    = w_byte ? (4'b1000 >> mem_addr_i[1:0]) :
                      w_half ? (mem_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    assign w_stdata = w_byte ? {4{mem_data_i[7:0]}} :
                      w_half ? {2{mem_data_i[15:0]}} : mem_data_i;

    // Lane 0 (addr offset 0) is the most significant byte.
    always_comb begin
        case (r_off)
            2'd0:    w_rbyte = bus_rdata_i[31:24];
            2'd1:    w_rbyte = bus_rdata_i[23:16];
            2'd2:    w_rbyte = bus_rdata_i[15:8];
            default: w_rbyte = bus_rdata_i[7:0];
        endcase
        w_rhalf = r_off[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        case (r_op)
            EXE_LB_OP:  w_ldata = {{24{w_rbyte[7]}}, w_rbyte};
            EXE_LBU_OP: w_ldata = {24'b0, w_rbyte};
            EXE_LH_OP:  w_ldata = {{16{w_rhalf[15]}}, w_rhalf};
            EXE_LHU_OP: w_ldata = {16'b0, w_rhalf};
            default:    w_ldata = bus_rdata_i;
        endcase
    end

    assign w_lim = (r_cnt == CW'(BUS_TIMEOUT - 1));

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_wd_nx     = wd_o;
        w_wreg_nx   = 1'b0;
        w_wdata_nx  = wdata_o;
        w_req_nx    = bus_req_o;
        w_we_nx     = bus_we_o;
        w_baddr_nx  = bus_addr_o;
        w_sel_nx    = bus_sel_o;
        w_bwdata_nx = bus_wdata_o;
        w_err_nx    = 1'b0;
        stallreq_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_mem) begin
                    w_wd_nx    = wd_i;
                    w_wreg_nx  = wreg_i;
                    w_wdata_nx = wdata_i;
                end else if (w_misalign) begin
                    w_wd_nx    = wd_i;
                    w_wdata_nx = 32'h0;
                    w_err_nx   = 1'b1;
                end else begin
                    stallreq_o  = 1'b1;
                    w_wd_nx     = wd_i;
                    w_req_nx    = 1'b1;
                    w_we_nx     = w_store;
                    w_baddr_nx  = {mem_addr_i[31:2], 2'b00};
                    w_sel_nx    = w_sel;
                    w_bwdata_nx = w_store ? w_stdata : 32'h0;
                    w_cnt_nx    = '0;
                    w_state_nx  = S_WAIT;
                end
            end
            default: begin
                if (bus_ack_i) begin
                    w_req_nx   = 1'b0;
                    w_state_nx = S_IDLE;
                    if (!bus_we_o) begin
                        w_wd_nx    = r_wd;
                        w_wreg_nx  = r_wreg;
                        w_wdata_nx = w_ldata;
                    end
                end else if (w_lim) begin
                    // Ack never came: abandon the access and flag it.
                    w_req_nx   = 1'b0;
                    w_err_nx   = 1'b1;
                    w_wdata_nx = 32'h0;
                    w_state_nx = S_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
        endcase
        if (rst) stallreq_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 8'h0;
            r_off       <= 2'b00;
            r_wd        <= 5'h0;
            r_wreg      <= 1'b0;
            wd_o        <= 5'h0;
            wreg_o      <= 1'b0;
            wdata_o     <= 32'h0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= 32'h0;
            bus_err_o   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            if (r_state == S_IDLE) begin
                r_op   <= aluop_i;
                r_off  <= mem_addr_i[1:0];
                r_wd   <= wd_i;
                r_wreg <= wreg_i;
            end
            wd_o        <= w_wd_nx;
            wreg_o      <= w_wreg_nx;
            wdata_o     <= w_wdata_nx;
            bus_req_o   <= w_req_nx;
            bus_we_o    <= w_we_nx;
            bus_addr_o  <= w_baddr_nx;
            bus_sel_o   <= w_sel_nx;
            bus_wdata_o <= w_bwdata_nx;
            bus_err_o   <= w_err_nx;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then randomized ops against a
// byte-arithmetic reference model of lane steering and extension.
module tb_mem_access;
    localparam int T = 4;
    localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4,
                           OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB,
                           OP_OR = 8'h25;

    logic        clk = 0, rst = 1;
    logic [7:0]  aluop_i = OP_OR;
    logic [4:0]  wd_i = 0;
    logic        wreg_i = 0;
    logic [31:0] wdata_i = 0, mem_addr_i = 0, mem_data_i = 0, bus_rdata_i = 0;
    logic        bus_ack_i = 0;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o, bus_req_o, bus_we_o, bus_err_o;
    logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    int passed = 0, total = 0;
    logic [7:0] ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    mem_access #(.BUS_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aluop_i = OP_OR; wd_i = 0; wreg_i = 0; wdata_i = 0;
    endtask

    function automatic int sz(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    // Big-endian: an access of s bytes at offset off covers bytes off..off+s-1
    // counted from the MSB, i.e. it sits (4-s-off) bytes above bit 0.
    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int s = sz(op);
        int off = int'(a[1:0]);
        return 4'(((1 << s) - 1) << (4 - s - off));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] rt);
        int s = sz(op);
        if (s == 1) return {24'b0, rt[7:0]} * 32'h0101_0101;
        if (s == 2) return {16'b0, rt[15:0]} * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        int s = sz(op);
        int sh = 8 * (4 - s - int'(a[1:0]));
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 1);
        logic [31:0] v = (rd >> sh) & mask;
        bit sgn = (op == OP_LB) || (op == OP_LH);
        if (sgn && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    // waits = number of cycles without ack in WAIT; waits >= T means no ack at all.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int waits);
        int s = sz(op);
        bit mis = (s == 2 && addr[0]) || (s == 4 && addr[1:0] != 2'b00);
        bit ld = is_load(op);
        logic [4:0] wd = 5'($urandom);
        logic [31:0] ea = {addr[31:2], 2'b00};
        aluop_i = op; mem_addr_i = addr; mem_data_i = rt; wd_i = wd; wreg_i = 1;
        wdata_i = $urandom; bus_ack_i = 0;
        #1 chk("issue_stall", 32'(stallreq_o), 32'(!mis));
        tick();
        if (mis) begin
            chk("mis_err", 32'(bus_err_o), 1);
            chk("mis_req", 32'(bus_req_o), 0);
            chk("mis_wreg", 32'(wreg_o), 0);
            chk("mis_wdata", wdata_o, 0);
            chk("mis_wd", 32'(wd_o), 32'(wd));
            idle(); tick();
            chk("mis_err_pulse", 32'(bus_err_o), 0);
            return;
        end
        chk("req", 32'(bus_req_o), 1);
        chk("we", 32'(bus_we_o), 32'(!ld));
        chk("addr", bus_addr_o, ea);
        chk("sel", 32'(bus_sel_o), 32'(m_sel(op, addr)));
        chk("bubble_wreg", 32'(wreg_o), 0);
        if (!ld) chk("bwdata", bus_wdata_o, m_wdata(op, rt));
        for (int i = 0; i < waits && i < T; i++) begin
            #1 chk("wait_stall", 32'(stallreq_o), 32'(i != T - 1));
            tick();
            if (i == T - 1) begin
                chk("to_err", 32'(bus_err_o), 1);
                chk("to_req", 32'(bus_req_o), 0);
                chk("to_wreg", 32'(wreg_o), 0);
                chk("to_wdata", wdata_o, 0);
                idle(); tick();
                chk("to_err_pulse", 32'(bus_err_o), 0);
                return;
            end
            chk("hold_req", 32'(bus_req_o), 1);
            chk("hold_addr", bus_addr_o, ea);
            chk("hold_sel", 32'(bus_sel_o), 32'(m_sel(op, addr)));
            if (!ld) chk("hold_bwdata", bus_wdata_o, m_wdata(op, rt));
            chk("hold_wreg", 32'(wreg_o), 0);
        end
        bus_ack_i = 1; bus_rdata_i = rdata;
        #1 chk("ack_stall", 32'(stallreq_o), 0);
        tick();
        bus_ack_i = 0; bus_rdata_i = $urandom; idle();
        chk("done_req", 32'(bus_req_o), 0);
        chk("done_err", 32'(bus_err_o), 0);
        chk("done_wreg", 32'(wreg_o), 32'(ld));
        if (ld) begin
            chk("load_data", wdata_o, m_load(op, addr, rdata));
            chk("load_wd", 32'(wd_o), 32'(wd));
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_req", 32'(bus_req_o), 0);
        chk("rst_wreg", 32'(wreg_o), 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_err", 32'(bus_err_o), 0);
        chk("rst_stall", 32'(stallreq_o), 0);
        rst = 0;

        // Reset in the middle of an open WAIT; a late ack must be ignored.
        aluop_i = OP_LW; mem_addr_i = 32'h100; wd_i = 3; wreg_i = 1;
        tick();
        chk("pre_rst_req", 32'(bus_req_o), 1);
        rst = 1;
        #1 chk("rst_wait_stall", 32'(stallreq_o), 0);
        tick();
        chk("rst_wait_req", 32'(bus_req_o), 0);
        chk("rst_wait_wreg", 32'(wreg_o), 0);
        tick();
        rst = 0; idle(); bus_ack_i = 1;
        #1 chk("late_ack_stall", 32'(stallreq_o), 0);
        tick();
        bus_ack_i = 0;
        chk("late_ack_req", 32'(bus_req_o), 0);
        chk("late_ack_err", 32'(bus_err_o), 0);
        chk("late_ack_wreg", 32'(wreg_o), 0);

        // Pass-through
        aluop_i = OP_OR; wd_i = 5; wreg_i = 1; wdata_i = 32'h1234_5678;
        #1 chk("pt_stall", 32'(stallreq_o), 0);
        tick();
        chk("pt_wd", 32'(wd_o), 5);
        chk("pt_wreg", 32'(wreg_o), 1);
        chk("pt_wdata", wdata_o, 32'h1234_5678);
        idle();

        do_mem(OP_LB,  32'h1003, 32'h0, 32'hAABB_CC80, 0);
        chk("lb_value", wdata_o, 32'hFFFF_FF80);
        do_mem(OP_LBU, 32'h1003, 32'h0, 32'hAABB_CC80, 0);
        chk("lbu_value", wdata_o, 32'h0000_0080);
        do_mem(OP_SH,  32'h2002, 32'h0000_BEEF, 32'h0, 3);
        do_mem(OP_LW,  32'h1001, 32'h0, 32'h0, 0);
        do_mem(OP_LW,  32'h3000, 32'h0, 32'h0, T);
        do_mem(OP_LW,  32'h3000, 32'h0, 32'hCAFE_F00D, T - 1);
        chk("late_lw_value", wdata_o, 32'hCAFE_F00D);

        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 8);
            if (k == 8) begin
                logic [4:0] wd = 5'($urandom);
                logic [31:0] d = $urandom;
                logic wr = 1'($urandom);
                aluop_i = OP_OR; wd_i = wd; wreg_i = wr; wdata_i = d;
                bus_ack_i = 1'($urandom);
                #1 chk("rpt_stall", 32'(stallreq_o), 0);
                tick();
                bus_ack_i = 0;
                chk("rpt_wd", 32'(wd_o), 32'(wd));
                chk("rpt_wreg", 32'(wreg_o), 32'(wr));
                chk("rpt_wdata", wdata_o, d);
                chk("rpt_req", 32'(bus_req_o), 0);
            end else begin
                logic [31:0] a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = (sz(ops[k]) == 2) ? {a[1], 1'b0} :
                                                        (sz(ops[k]) == 4) ? 2'b00 : a[1:0];
                do_mem(ops[k], a, $urandom, $urandom, $urandom_range(0, T));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
